// File: rtl/fsk_bit_decoder.sv
// FSK bit decoder: sequences frequency_analyzer once per bit period, decides each bit from the
// f0/f1 counts and assembles LSB-first words, flagging periods with too little carrier energy.
module fsk_bit_decoder #(
    parameter int unsigned CLOCK_FREQUENCY  = 50000000,
    parameter int unsigned BIT_RATE         = 1000,
    parameter int unsigned ANALYZER_LATENCY = 2,
    parameter int unsigned MIN_COUNT        = 16,
    parameter int unsigned DATA_WIDTH       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [31:0]           f0_value,
    input  logic [31:0]           f1_value,
    output logic                  analyzer_clear,
    output logic                  analyzer_enable,
    output logic                  bit_valid,
    output logic                  bit_value,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    output logic                  carrier_lost
);

    localparam int unsigned BIT_PERIOD    = CLOCK_FREQUENCY / BIT_RATE;
    localparam int unsigned INTEGRATE_LEN = BIT_PERIOD - 2 - ANALYZER_LATENCY;
    localparam int unsigned BCNT_W        = $clog2(DATA_WIDTH);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CLEAR     = 3'd1;
    localparam logic [2:0] ST_INTEGRATE = 3'd2;
    localparam logic [2:0] ST_WAIT      = 3'd3;
    localparam logic [2:0] ST_DECIDE    = 3'd4;

    if (BIT_PERIOD < ANALYZER_LATENCY + 3) begin : g_bad_period
        $error("fsk_bit_decoder: BIT_PERIOD must be at least ANALYZER_LATENCY+3");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("fsk_bit_decoder: DATA_WIDTH must be at least 2");
    end

    logic [2:0]            state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [BCNT_W-1:0]     bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [32:0]           sum;
    logic                  low_energy;
    logic                  bit_decided;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_INTEGRATE;
                cnt_d   = 32'd0;
            end
            ST_INTEGRATE: begin
                if (cnt_q == 32'(INTEGRATE_LEN - 1)) begin
                    cnt_d   = 32'd0;
                    state_d = (ANALYZER_LATENCY == 0) ? ST_DECIDE : ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 32'(ANALYZER_LATENCY) - 32'd1) begin
                    cnt_d   = 32'd0;
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DECIDE: begin
                state_d = ST_CLEAR;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 32'd0;
            end
        endcase
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
        end
    end

    // 33-bit sum so two large counts cannot wrap below MIN_COUNT.
    always_comb begin
        sum         = {1'b0, f0_value} + {1'b0, f1_value};
        low_energy  = sum < 33'(MIN_COUNT);
        bit_decided = f1_value > f0_value;
        shift_next  = {bit_decided, shift_q[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 32'd0;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            analyzer_clear  <= 1'b0;
            analyzer_enable <= 1'b0;
            bit_valid       <= 1'b0;
            bit_value       <= 1'b0;
            word_data       <= '0;
            word_valid      <= 1'b0;
            carrier_lost    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            analyzer_clear  <= (state_d == ST_CLEAR);
            analyzer_enable <= (state_d == ST_INTEGRATE);
            bit_valid       <= 1'b0;
            word_valid      <= 1'b0;
            carrier_lost    <= 1'b0;
            if (!enable) begin
                // Disabling drops any partial word, including a decision due this cycle.
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (state_q == ST_DECIDE) begin
                if (low_energy) begin
                    carrier_lost <= 1'b1;
                    bit_cnt_q    <= '0;
                    shift_q      <= '0;
                end else begin
                    bit_valid <= 1'b1;
                    bit_value <= bit_decided;
                    shift_q   <= shift_next;
                    if (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
                        word_valid <= 1'b1;
                        word_data  <= shift_next;
                        bit_cnt_q  <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fsk_bit_decoder.sv
// Self-checking bench for fsk_bit_decoder with BIT_PERIOD=10, ANALYZER_LATENCY=2, 8-bit words.
module tb_fsk_bit_decoder;

    localparam int unsigned DW   = 8;
    localparam longint      MINC = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [31:0]   f0_value;
    logic [31:0]   f1_value;
    logic          analyzer_clear;
    logic          analyzer_enable;
    logic          bit_valid;
    logic          bit_value;
    logic [DW-1:0] word_data;
    logic          word_valid;
    logic          carrier_lost;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: results of the period just run, shown at the next period start.
    bit            exp_bv, exp_bval, exp_wv, exp_cl;
    logic [DW-1:0] next_wd;
    logic [DW-1:0] hold_wd;
    bit            bits_q[$];

    fsk_bit_decoder #(
        .CLOCK_FREQUENCY (1000),
        .BIT_RATE        (100),
        .ANALYZER_LATENCY(2),
        .MIN_COUNT       (16),
        .DATA_WIDTH      (DW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .f0_value       (f0_value),
        .f1_value       (f1_value),
        .analyzer_clear (analyzer_clear),
        .analyzer_enable(analyzer_enable),
        .bit_valid      (bit_valid),
        .bit_value      (bit_value),
        .word_data      (word_data),
        .word_valid     (word_valid),
        .carrier_lost   (carrier_lost)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] ctl_vec();
        return {analyzer_clear, analyzer_enable, bit_valid, word_valid, carrier_lost};
    endfunction

    // Called at the negedge of the CLEAR cycle that starts a period.
    task automatic phase0_check(input string tag);
        logic [4:0] want;
        want = {1'b1, 1'b0, exp_bv, exp_wv, exp_cl};
        if (exp_wv) hold_wd = next_wd;
        tests_run++;
        if (ctl_vec() !== want) begin
            tests_failed++;
            $display("FAIL %s start ctl {clr,aen,bv,wv,cl}: got %b want %b", tag, ctl_vec(), want);
        end
        if (exp_bv) begin
            tests_run++;
            if (bit_value !== exp_bval) begin
                tests_failed++;
                $display("FAIL %s bit_value: got %b want %b", tag, bit_value, exp_bval);
            end
        end
        tests_run++;
        if (word_data !== hold_wd) begin
            tests_failed++;
            $display("FAIL %s word_data: got %h want %h", tag, word_data, hold_wd);
        end
        exp_bv = 0; exp_wv = 0; exp_cl = 0;
    endtask

    // Entered at a period start (already checked); leaves at the next period start.
    task automatic run_period(input logic [31:0] f0, input logic [31:0] f1, input string tag);
        longint     s;
        logic [4:0] want;
        f0_value = f0;
        f1_value = f1;
        s = longint'(f0) + longint'(f1);
        if (s < MINC) begin
            exp_cl = 1;
            bits_q.delete();
        end else begin
            exp_bv   = 1;
            exp_bval = (f1 > f0);
            bits_q.push_back(exp_bval);
            if (bits_q.size() == DW) begin
                for (int i = 0; i < DW; i++) next_wd[i] = bits_q[i];
                exp_wv = 1;
                bits_q.delete();
            end
        end
        for (int ph = 1; ph <= 9; ph++) begin
            @(negedge clock);
            want = {1'b0, (ph <= 6), 3'b000};
            tests_run++;
            if (ctl_vec() !== want || word_data !== hold_wd) begin
                tests_failed++;
                $display("FAIL %s phase %0d ctl/word: got %b/%h want %b/%h",
                         tag, ph, ctl_vec(), word_data, want, hold_wd);
            end
        end
        @(negedge clock);
        phase0_check(tag);
    endtask

    // Interrupt a period after k clocks by enable=0 or a reset pulse, then restart.
    task automatic abort_period(input int k, input bit use_reset, input string tag);
        f0_value = 32'd10;
        f1_value = 32'd50;
        repeat (k) @(negedge clock);
        if (use_reset) reset = 1'b1;
        else enable = 1'b0;
        @(negedge clock);
        bits_q.delete();
        if (use_reset) hold_wd = '0;
        tests_run++;
        if (ctl_vec() !== 5'b0 || word_data !== hold_wd) begin
            tests_failed++;
            $display("FAIL %s abort@%0d ctl/word: got %b/%h want 00000/%h",
                     tag, k, ctl_vec(), word_data, hold_wd);
        end
        reset  = 1'b0;
        enable = 1'b1;
        @(negedge clock);
        phase0_check({tag, "_restart"});
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; f0_value = 32'd0; f1_value = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            tests_run++;
            if (ctl_vec() !== 5'b0 || word_data !== '0 || bit_value !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset cycle %0d: ctl %b word %h bv %b, want all 0",
                         i, ctl_vec(), word_data, bit_value);
            end
        end
        reset = 1'b0;
        exp_bv = 0; exp_wv = 0; exp_cl = 0; hold_wd = '0; next_wd = '0;
        bits_q.delete();
        @(negedge clock);
        phase0_check("reset_first_clear");
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < 8; i++) run_period(32'd10, 32'd50, "all_ones");
        tests_run++;
        if (word_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL all_ones word: got %h want ff", word_data);
        end
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) run_period(32'd5, 32'd40, "alternate");
            else run_period(32'd40, 32'd5, "alternate");
        end
        tests_run++;
        if (word_data !== 8'h55) begin
            tests_failed++;
            $display("FAIL alternate word: got %h want 55", word_data);
        end
    endtask

    task automatic test_tie();
        for (int i = 0; i < 8; i++) run_period(32'd20, 32'd20, "tie");
        tests_run++;
        if (word_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL tie word: got %h want 00", word_data);
        end
    endtask

    task automatic test_carrier_lost();
        for (int i = 0; i < 3; i++) run_period(32'd10, 32'd50, "lost_pre");
        run_period(32'd5, 32'd5, "lost");
        for (int i = 0; i < 8; i++) run_period(32'd10, 32'd50, "lost_post");
        tests_run++;
        if (word_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL lost word: got %h want ff", word_data);
        end
    endtask

    task automatic test_disable_and_reset();
        for (int i = 0; i < 3; i++) run_period(32'd50, 32'd10, "dis_pre");
        abort_period(1, 1'b0, "disable");
        for (int i = 0; i < 8; i++) run_period(32'd10, 32'd50, "dis_post");
        tests_run++;
        if (word_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL disable word: got %h want ff", word_data);
        end
        for (int i = 0; i < 3; i++) run_period(32'd50, 32'd10, "rst_pre");
        abort_period(3, 1'b1, "reset_mid");
        for (int i = 0; i < 8; i++) run_period(32'd10, 32'd50, "rst_post");
        tests_run++;
        if (word_data !== 8'hFF) begin
            tests_failed++;
            $display("FAIL reset_mid word: got %h want ff", word_data);
        end
        // Disable landing on the decide cycle must discard that bit.
        run_period(32'd10, 32'd50, "decide_pre");
        abort_period(9, 1'b0, "disable_decide");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        int          kind;
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            a = $urandom_range(0, 100);
            b = $urandom_range(0, 100);
            case (kind)
                0: begin a = $urandom_range(0, 8); b = $urandom_range(0, 7); end
                1: b = a;
                2: begin a = 32'hFFFF_FFF0 + $urandom_range(0, 15); b = $urandom_range(0, 20); end
                3: begin b = 32'hFFFF_FFF0 + $urandom_range(0, 15); a = $urandom_range(0, 20); end
                default: ;
            endcase
            if (kind == 9) abort_period(int'($urandom_range(1, 9)), $urandom_range(0, 1) == 1, "rand_abort");
            else run_period(a, b, "random");
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_alternate();
        test_tie();
        test_carrier_lost();
        test_disable_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
